triangle_intlv_ctrl: RTL and testbench

Sequencing controller that drives one triangleSR instance through a full interleave frame. It runs three phases in order: fill (32-bit writes), diagonal shift, then drain (single-bit or N-bit reads). Upstream word stream connects via valid/ready; drained bits go downstream via valid/ready. At most one triangleSR operation enable is asserted per cycle, so the bound state-dump monitor always decodes an unambiguous mode.

---
 rtl/triangle_intlv_ctrl.sv | 229 ++++++++++++++++++++++
 tb/tb_triangle_intlv_ctrl.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/triangle_intlv_ctrl.sv
// Purpose : sequences one triangleSR through a frame: fill (wr32), diagonal shift, drain (rd1/rdN*).
// Latency : fill words pass through combinationally; drained beats appear one cycle after the read issues.
// Backpress: in_ready only in FILL; a stalled output beat holds stable and blocks further reads.
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   start, rd_mode        frame start pulse (IDLE only) and read mode latched with it
//   busy, done            frame in progress / one-cycle completion pulse
//   in_valid/ready/data   upstream 32-bit word stream (FILL phase)
//   wr32_en/data          triangleSR 32-bit write port
//   wr1_en/data           triangleSR single-bit write port, unused (tied 0)
//   diag_shift_en         triangleSR diagonal shift
//   rd1_en..rdN3_en       triangleSR read enables, one per width
//   sr_rd_data            triangleSR read data, valid in the cycle a read enable is high
//   out_valid/ready       downstream beat handshake
//   out_data/nbits/last   drained bits (LSB-aligned), valid bit count, final-beat flag
module triangle_intlv_ctrl #(
    parameter int SIDE        = 128,
    parameter int TOTAL_BITS  = SIDE * (SIDE + 1) / 2,
    parameter int FILL_WORDS  = TOTAL_BITS / 32,
    parameter int DIAG_CYCLES = SIDE,
    parameter int N1          = 38,
    parameter int N2          = 11,
    parameter int N3          = 3
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic [1:0]    rd_mode,
    output logic          busy,
    output logic          done,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [31:0]   in_data,
    output logic          wr32_en,
    output logic [31:0]   wr32_data,
    output logic          wr1_en,
    output logic          wr1_data,
    output logic          diag_shift_en,
    output logic          rd1_en,
    output logic          rdN1_en,
    output logic          rdN2_en,
    output logic          rdN3_en,
    input  logic [N1-1:0] sr_rd_data,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [N1-1:0] out_data,
    output logic [5:0]    out_nbits,
    output logic          out_last
);

    // Beats per frame for each read width (ceiling division).
    localparam int BEATS_1  = TOTAL_BITS;
    localparam int BEATS_N1 = (TOTAL_BITS + N1 - 1) / N1;
    localparam int BEATS_N2 = (TOTAL_BITS + N2 - 1) / N2;
    localparam int BEATS_N3 = (TOTAL_BITS + N3 - 1) / N3;

    localparam int WC_W = $clog2(FILL_WORDS + 1);
    localparam int DC_W = (DIAG_CYCLES > 0) ? $clog2(DIAG_CYCLES + 1) : 1;
    localparam int BC_W = $clog2(TOTAL_BITS + 1);

    localparam logic [WC_W-1:0] WC_LAST = WC_W'(FILL_WORDS - 1);
    localparam logic [DC_W-1:0] DC_LAST = DC_W'((DIAG_CYCLES > 0) ? DIAG_CYCLES - 1 : 0);

    localparam logic [BC_W-1:0] LAST_IDX_1  = BC_W'(BEATS_1 - 1);
    localparam logic [BC_W-1:0] LAST_IDX_N1 = BC_W'(BEATS_N1 - 1);
    localparam logic [BC_W-1:0] LAST_IDX_N2 = BC_W'(BEATS_N2 - 1);
    localparam logic [BC_W-1:0] LAST_IDX_N3 = BC_W'(BEATS_N3 - 1);

    localparam logic [5:0] W_1  = 6'd1;
    localparam logic [5:0] W_N1 = 6'(N1);
    localparam logic [5:0] W_N2 = 6'(N2);
    localparam logic [5:0] W_N3 = 6'(N3);

    // Bits left over for the final beat of each mode.
    localparam logic [5:0] TAIL_1  = 6'(TOTAL_BITS - (BEATS_1  - 1) * 1);
    localparam logic [5:0] TAIL_N1 = 6'(TOTAL_BITS - (BEATS_N1 - 1) * N1);
    localparam logic [5:0] TAIL_N2 = 6'(TOTAL_BITS - (BEATS_N2 - 1) * N2);
    localparam logic [5:0] TAIL_N3 = 6'(TOTAL_BITS - (BEATS_N3 - 1) * N3);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FILL,
        S_DIAG,
        S_READ,
        S_FLUSH
    } state_t;

    state_t          state;
    logic [1:0]      mode_q;
    logic [WC_W-1:0] word_cnt;
    logic [DC_W-1:0] diag_cnt;
    logic [BC_W-1:0] beat_cnt;

    logic            fill_hs;
    logic            rd_issue;
    logic [BC_W-1:0] beat_last_idx;
    logic [5:0]      beat_w;
    logic [5:0]      beat_tail;
    logic            is_last_beat;
    logic [5:0]      beat_nbits;
    logic [N1-1:0]   beat_mask;

    // Triangle enables are decoded from state so that exactly one phase can
    // drive the triangleSR in any cycle.
    assign fill_hs  = (state == S_FILL) && in_valid;
    // A new read may only be taken when the output register is free or
    // being emptied this cycle.
    assign rd_issue = (state == S_READ) && (!out_valid || out_ready);

    assign in_ready      = (state == S_FILL);
    assign wr32_en       = fill_hs;
    assign wr32_data     = fill_hs ? in_data : 32'd0;
    assign wr1_en        = 1'b0;
    assign wr1_data      = 1'b0;
    assign diag_shift_en = (state == S_DIAG);
    assign rd1_en        = rd_issue && (mode_q == 2'd0);
    assign rdN1_en       = rd_issue && (mode_q == 2'd1);
    assign rdN2_en       = rd_issue && (mode_q == 2'd2);
    assign rdN3_en       = rd_issue && (mode_q == 2'd3);

    always_comb begin
        beat_last_idx = LAST_IDX_1;
        beat_w        = W_1;
        beat_tail     = TAIL_1;
        case (mode_q)
            2'd1: begin
                beat_last_idx = LAST_IDX_N1;
                beat_w        = W_N1;
                beat_tail     = TAIL_N1;
            end
            2'd2: begin
                beat_last_idx = LAST_IDX_N2;
                beat_w        = W_N2;
                beat_tail     = TAIL_N2;
            end
            2'd3: begin
                beat_last_idx = LAST_IDX_N3;
                beat_w        = W_N3;
                beat_tail     = TAIL_N3;
            end
            default: ;
        endcase
    end

    assign is_last_beat = (beat_cnt == beat_last_idx);
    assign beat_nbits   = is_last_beat ? beat_tail : beat_w;
    // Keeps only the low beat_nbits bits; a shift of N1 or more yields all ones.
    assign beat_mask    = ~({N1{1'b1}} << beat_nbits);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            mode_q    <= 2'd0;
            word_cnt  <= '0;
            diag_cnt  <= '0;
            beat_cnt  <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_nbits <= 6'd0;
            out_last  <= 1'b0;
        end else begin
            done <= 1'b0;

            // Output register empties on handshake; a read issued in the
            // same cycle refills it below.
            if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end

            case (state)
                S_IDLE: begin
                    if (start) begin
                        mode_q   <= rd_mode;
                        word_cnt <= '0;
                        diag_cnt <= '0;
                        beat_cnt <= '0;
                        busy     <= 1'b1;
                        state    <= S_FILL;
                    end
                end

                S_FILL: begin
                    if (fill_hs) begin
                        word_cnt <= word_cnt + WC_W'(1);
                        if (word_cnt == WC_LAST) begin
                            state <= (DIAG_CYCLES == 0) ? S_READ : S_DIAG;
                        end
                    end
                end

                S_DIAG: begin
                    diag_cnt <= diag_cnt + DC_W'(1);
                    if (diag_cnt == DC_LAST) begin
                        state <= S_READ;
                    end
                end

                S_READ: begin
                    if (rd_issue) begin
                        out_valid <= 1'b1;
                        out_data  <= sr_rd_data & beat_mask;
                        out_nbits <= beat_nbits;
                        out_last  <= is_last_beat;
                        beat_cnt  <= beat_cnt + BC_W'(1);
                        if (is_last_beat) begin
                            state <= S_FLUSH;
                        end
                    end
                end

                S_FLUSH: begin
                    // Final beat is already in the output register; finish
                    // once it has been taken.
                    if (out_valid && out_ready) begin
                        done  <= 1'b1;
                        busy  <= 1'b0;
                        state <= S_IDLE;
                    end
                end

                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_triangle_intlv_ctrl.sv
// Purpose : randomized scoreboard bench for triangle_intlv_ctrl against a frame-level model.
// Latency : expected beats are queued when a read enable is seen and popped on the output handshake.
// Backpress: downstream ready is driven always-high, toggling or random per frame.
`timescale 1ns/1ps
module tb_triangle_intlv_ctrl;

    localparam int SIDE        = 128;
    localparam int TOTAL_BITS  = SIDE * (SIDE + 1) / 2;
    localparam int FILL_WORDS  = TOTAL_BITS / 32;
    localparam int DIAG_CYCLES = SIDE;
    localparam int N1          = 38;
    localparam int N2          = 11;
    localparam int N3          = 3;

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic          start = 1'b0;
    logic [1:0]    rd_mode = 2'd0;
    logic          busy, done;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [31:0]   in_data = 32'd0;
    logic          wr32_en;
    logic [31:0]   wr32_data;
    logic          wr1_en, wr1_data;
    logic          diag_shift_en;
    logic          rd1_en, rdN1_en, rdN2_en, rdN3_en;
    logic [N1-1:0] sr_rd_data = '0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [N1-1:0] out_data;
    logic [5:0]    out_nbits;
    logic          out_last;

    always #5 clk = ~clk;

    triangle_intlv_ctrl #(
        .SIDE(SIDE), .TOTAL_BITS(TOTAL_BITS), .FILL_WORDS(FILL_WORDS),
        .DIAG_CYCLES(DIAG_CYCLES), .N1(N1), .N2(N2), .N3(N3)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .rd_mode(rd_mode),
        .busy(busy), .done(done),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .wr32_en(wr32_en), .wr32_data(wr32_data),
        .wr1_en(wr1_en), .wr1_data(wr1_data),
        .diag_shift_en(diag_shift_en),
        .rd1_en(rd1_en), .rdN1_en(rdN1_en), .rdN2_en(rdN2_en), .rdN3_en(rdN3_en),
        .sr_rd_data(sr_rd_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_nbits(out_nbits), .out_last(out_last)
    );

    typedef struct {
        logic [63:0] data;
        logic [5:0]  nbits;
        logic        last;
    } beat_t;

    beat_t exp_q[$];

    int n_checks = 0;
    int n_fail   = 0;
    int pending_mode = 0;
    int exp_mode = 0;
    int fill_idx = 0;
    int diag_cnt = 0;
    int rd_idx   = 0;
    int frames_done = 0;
    bit done_due  = 1'b0;
    bit prev_diag = 1'b0;
    bit abort     = 1'b0;

    function automatic int width_of(input int m);
        case (m)
            0:       return 1;
            1:       return N1;
            2:       return N2;
            default: return N3;
        endcase
    endfunction

    function automatic int beats_of(input int m);
        return (TOTAL_BITS + width_of(m) - 1) / width_of(m);
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic check_all_zero(input string name);
        check({name, "_ctrl"},
              64'({busy, done, in_ready, wr32_en, wr1_en, wr1_data, diag_shift_en,
                   rd1_en, rdN1_en, rdN2_en, rdN3_en, out_valid, out_last, out_nbits}), 64'd0);
        check({name, "_wdata"}, 64'(wr32_data), 64'd0);
        check({name, "_odata"}, 64'(out_data), 64'd0);
    endtask

    // Monitor / scoreboard: sampled on the falling edge, away from the active edge.
    always @(negedge clk) begin
        if (rst_n) begin
            int         en_cnt;
            logic [3:0] rd_vec;
            beat_t      b;
            int         w, nb;

            rd_vec = {rdN3_en, rdN2_en, rdN1_en, rd1_en};
            en_cnt = int'(wr32_en) + int'(diag_shift_en) + int'(rd1_en) + int'(rdN1_en)
                   + int'(rdN2_en) + int'(rdN3_en);
            check("enable_onehot", 64'(en_cnt <= 1), 64'd1);
            check("wr1_tied_low", 64'({wr1_en, wr1_data}), 64'd0);

            // done must pulse exactly one cycle after the final handshake.
            check("done_pulse", 64'(done), 64'(done_due));
            if (done_due) begin
                check("done_out_valid_low", 64'(out_valid), 64'd0);
                check("done_busy_low", 64'(busy), 64'd0);
                check("frame_words", 64'(fill_idx), 64'(FILL_WORDS));
                check("frame_diag", 64'(diag_cnt), 64'(DIAG_CYCLES));
                check("frame_beats", 64'(rd_idx), 64'(beats_of(exp_mode)));
                check("frame_queue_empty", 64'(exp_q.size()), 64'd0);
                frames_done++;
                fill_idx = 0;
                diag_cnt = 0;
                rd_idx   = 0;
            end
            done_due = 1'b0;

            if (in_ready) begin
                check("fill_wr_follows_valid", 64'(wr32_en), 64'(in_valid));
                check("fill_no_other_en", 64'({diag_shift_en, rd_vec}), 64'd0);
            end
            if (wr32_en) begin
                if (fill_idx == 0) exp_mode = pending_mode;
                check("wr32_data", 64'(wr32_data), 64'(fill_idx));
                check("fill_before_diag_read", 64'(diag_cnt + rd_idx), 64'd0);
                fill_idx++;
            end

            if (diag_shift_en) begin
                check("diag_after_fill", 64'(fill_idx), 64'(FILL_WORDS));
                diag_cnt++;
            end
            if (prev_diag && !diag_shift_en)
                check("diag_run_length", 64'(diag_cnt), 64'(DIAG_CYCLES));
            prev_diag = diag_shift_en;

            // Output side: the head of the queue is the beat currently presented.
            if (out_valid) begin
                if (exp_q.size() == 0) begin
                    check("out_unexpected_beat", 64'd1, 64'd0);
                end else begin
                    check("out_data", 64'(out_data), exp_q[0].data);
                    check("out_nbits", 64'(out_nbits), 64'(exp_q[0].nbits));
                    check("out_last", 64'(out_last), 64'(exp_q[0].last));
                    if (out_ready) begin
                        if (exp_q[0].last) done_due = 1'b1;
                        void'(exp_q.pop_front());
                    end
                end
            end

            // Read side: model beat k carries min(W, TOTAL_BITS - k*W) bits of
            // the triangle data presented that cycle (rdN1 tail: 8256-217*38 = 10).
            if (rd_vec != 4'd0) begin
                check("rd_en_matches_mode", 64'(rd_vec), 64'(4'b0001 << exp_mode));
                check("rd_not_while_stalled", 64'(!out_valid || out_ready), 64'd1);
                check("rd_after_diag", 64'(diag_cnt), 64'(DIAG_CYCLES));
                check("rd_within_frame", 64'(rd_idx < beats_of(exp_mode)), 64'd1);
                w  = width_of(exp_mode);
                nb = TOTAL_BITS - rd_idx * w;
                if (nb > w) nb = w;
                b.data  = 64'(sr_rd_data) & ((64'd1 << nb) - 64'd1);
                b.nbits = 6'(nb);
                b.last  = (rd_idx == beats_of(exp_mode) - 1);
                exp_q.push_back(b);
                rd_idx++;
            end
        end
    end

    task automatic mid_frame_reset();
        #2 rst_n = 1'b0;
        #1 check_all_zero("async_reset");
        exp_q.delete();
        fill_idx  = 0;
        diag_cnt  = 0;
        rd_idx    = 0;
        done_due  = 1'b0;
        prev_diag = 1'b0;
        start     = 1'b0;
        in_valid  = 1'b0;
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("post_reset_busy", 64'(busy), 64'd0);
        check("post_reset_idle", 64'({in_ready, out_valid, diag_shift_en}), 64'd0);
    endtask

    // gap: 1 = in_valid only every third cycle; rdy_pat: 0 always, 1 toggle, 2 random;
    // poke: pulse start during DIAG and READ; rst_at: beat index for a mid-frame reset (-1 none).
    task automatic run_frame(input int mode, input int gap, input int rdy_pat,
                             input bit poke, input int rst_at);
        int cyc;
        bit fin;
        pending_mode = mode;
        start   = 1'b1;
        rd_mode = 2'(mode);
        @(posedge clk);
        #1;
        start   = 1'b0;
        rd_mode = 2'(~mode);
        check("busy_after_start", 64'(busy), 64'd1);
        cyc = 0;
        fin = 1'b0;
        while (!fin) begin
            in_valid = (gap == 0) || (cyc % 3 == 0);
            in_data  = in_valid ? 32'(fill_idx) : 32'hDEAD_BEEF;
            case (rdy_pat)
                0:       out_ready = 1'b1;
                1:       out_ready = ((cyc % 2) == 0);
                default: out_ready = ($urandom_range(0, 3) != 0);
            endcase
            sr_rd_data = N1'({$urandom(), $urandom()});
            start = poke && ((diag_cnt == 5) || (rd_idx == 7));
            if (rst_at >= 0 && rd_idx == rst_at) begin
                mid_frame_reset();
                return;
            end
            @(posedge clk);
            #1;
            cyc++;
            if (done) fin = 1'b1;
            if (poke && !fin && fill_idx > 0) check("busy_during_frame", 64'(busy), 64'd1);
            if (cyc > 40000) begin
                n_checks++;
                n_fail++;
                $display("FAIL frame_timeout: mode %0d ran %0d cycles without done", mode, cyc);
                abort = 1'b1;
                fin   = 1'b1;
            end
        end
        start    = 1'b0;
        in_valid = 1'b0;
    endtask

    initial begin
        #1 rst_n = 1'b0;
        #2 check_all_zero("reset_init");
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;
        @(posedge clk);
        #1;
        run_frame(1, 0, 0, 1'b0, -1);               // rdN1, full-rate streams
        if (!abort) run_frame(3, 0, 1, 1'b0, -1);   // rdN3, ready toggling (start in done cycle)
        if (!abort) run_frame(1, 1, 2, 1'b0, -1);   // gapped fill, random ready
        if (!abort) run_frame(0, 0, 2, 1'b1, -1);   // rd1, start poked mid-frame
        if (!abort) run_frame(2, 0, 2, 1'b1, 100);  // rdN2, reset at beat 100
        if (!abort) run_frame(2, 0, 0, 1'b0, -1);   // rdN2, clean frame after reset
        if (!abort) repeat (3) @(posedge clk);
        check("frames_completed", 64'(frames_done), 64'd5);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
